// File: rtl/mux_a_pipe.sv
// mux_a_pipe: selects the wide operand or the zero/sign-extended narrow operand,
// and buffers the selected word in a 2-entry FIFO with valid/ready handshakes
// on both sides.
// Optional feature: define MUX_A_PIPE_PARITY_EN to add out_par, the even parity of outA.
module mux_a_pipe #(
    parameter int DATA_W   = 32,
    parameter int NARROW_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in1,
    input  logic [NARROW_W-1:0] in2,
    input  logic              sel,
    input  logic              ext_sign,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] outA,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_A_PIPE_PARITY_EN
    ,
    output logic              out_par
`endif
);

    // Widen the narrow operand. When the widths are equal, the fill pattern
    // is overwritten entirely, so ext_sign has no effect.
    function automatic logic [DATA_W-1:0] extend(input logic [NARROW_W-1:0] v,
                                                 input logic s);
        logic [DATA_W-1:0] r;
        r = {DATA_W{s & v[NARROW_W-1]}};
        r[NARROW_W-1:0] = v;
        return r;
    endfunction

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;   // oldest word, drives outA
    logic [DATA_W-1:0] tail_q, tail_d;   // second word, valid only when count is 2
    logic [DATA_W-1:0] word;
    logic              push, pop;

    // Handshake flags. Both depend only on the registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign outA      = head_q;

`ifdef MUX_A_PIPE_PARITY_EN
    assign out_par = ^head_q;
`endif

    // Select and extend the incoming word for storage.
    always_comb begin
        word = sel ? in1 : extend(in2, ext_sign);
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
    end

    // FIFO next-state logic. A simultaneous push and pop can only happen at count 1,
    // in which case the new word replaces the departing head.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = word;
                    count_d = 2'd1;
                end else begin
                    tail_d  = word;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'b11: begin
                head_d = word;
            end
            default: begin
            end
        endcase
    end

    // Occupancy and head register. The head is cleared on reset so outA reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    // Second-entry storage. It is never observed until rewritten after reset, so it needs no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

endmodule

// File: tb/tb_mux_a_pipe.sv
module tb_mux_a_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1;
    logic [15:0] in2;
    logic        sel, ext_sign, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] outA;
    logic        out_par;

    // 16/16 instance
    logic [15:0] w_in1, w_in2, w_out;
    logic        w_ext, w_ir, w_ov, w_par;
    // 32/8 instance
    logic [31:0] n_in1, n_out;
    logic [7:0]  n_in2;
    logic        n_ext, n_ir, n_ov, n_par;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_a_pipe #(.DATA_W(32), .NARROW_W(16)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sel(sel), .ext_sign(ext_sign),
        .in_valid(in_valid), .in_ready(in_ready), .outA(outA), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_A_PIPE_PARITY_EN
        , .out_par(out_par)
`endif
    );

    mux_a_pipe #(.DATA_W(16), .NARROW_W(16)) dut_w (
        .clk(clk), .rst(rst), .in1(w_in1), .in2(w_in2), .sel(1'b0), .ext_sign(w_ext),
        .in_valid(1'b1), .in_ready(w_ir), .outA(w_out), .out_valid(w_ov),
        .out_ready(1'b1)
`ifdef MUX_A_PIPE_PARITY_EN
        , .out_par(w_par)
`endif
    );

    mux_a_pipe #(.DATA_W(32), .NARROW_W(8)) dut_n (
        .clk(clk), .rst(rst), .in1(n_in1), .in2(n_in2), .sel(1'b0), .ext_sign(n_ext),
        .in_valid(1'b1), .in_ready(n_ir), .outA(n_out), .out_valid(n_ov),
        .out_ready(1'b1)
`ifdef MUX_A_PIPE_PARITY_EN
        , .out_par(n_par)
`endif
    );

    typedef struct {
        logic        sel;
        logic        ext;
        logic [31:0] in1;
        logic [15:0] in2;
        logic [31:0] exp;
        logic        exp_par;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'hA5A5A5A5, 16'h0000, 32'hA5A5A5A5, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'h00000000, 16'h1234, 32'h00001234, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'h00000000, 16'hABCD, 32'hFFFFABCD, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFFFFFF, 16'hABCD, 32'h0000ABCD, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h00000000, 16'h7FFF, 32'h00007FFF, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'h00000000, 16'h8000, 32'hFFFF8000, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h00000007, 16'hFFFF, 32'h00000007, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 32'h00000003, 16'hFFFF, 32'h00000003, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'h00000000, 16'hFFFF, 32'h00000000, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'h12345678, 16'hFFFF, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1; in1 = '0; in2 = '0; sel = 1'b0; ext_sign = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        w_in1 = '0; w_in2 = 16'h8000; w_ext = 1'b1;
        n_in1 = '0; n_in2 = 8'h80; n_ext = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outA", outA, 32'd0);
`ifdef MUX_A_PIPE_PARITY_EN
        check("rst_out_par", {31'd0, out_par}, 32'd0);
`endif

        // Extension on the alternate-width instances
        tick();
        check("w16_sext", {16'd0, w_out}, 32'h00008000);
        check("n8_sext", n_out, 32'hFFFFFF80);
        n_ext = 1'b0;
        tick();
        check("n8_zext", n_out, 32'h00000080);
        w_ext = 1'b0;
        tick();
        check("w16_zext", {16'd0, w_out}, 32'h00008000);

        // Streaming table, out_ready=1, each word appears one cycle after acceptance
        sel = vecs[0].sel; ext_sign = vecs[0].ext; in1 = vecs[0].in1; in2 = vecs[0].in2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("vec%0d_outA", i), outA, vecs[i].exp);
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
`ifdef MUX_A_PIPE_PARITY_EN
            check($sformatf("vec%0d_par", i), {31'd0, out_par}, {31'd0, vecs[i].exp_par});
`endif
            if (i < 9) begin
                sel = vecs[i+1].sel; ext_sign = vecs[i+1].ext;
                in1 = vecs[i+1].in1; in2 = vecs[i+1].in2;
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill two, third held, then drain in order
        out_ready = 1'b0; sel = 1'b1;
        in1 = 32'hB6B6B6B6; in_valid = 1'b1;
        tick();
        check("bp1_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp1_outA", outA, 32'hB6B6B6B6);
        in1 = 32'hC7C7C7C7;
        tick();
        check("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp2_outA", outA, 32'hB6B6B6B6);
        in1 = 32'h11111111;
        tick();
        check("bp3_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp3_hold_outA", outA, 32'hB6B6B6B6);
        out_ready = 1'b1;
        tick();
        check("bp4_outA", outA, 32'hC7C7C7C7);
        check("bp4_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp5_outA", outA, 32'h11111111);
        check("bp5_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp6_valid", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop at count 1
        out_ready = 1'b0; in1 = 32'h00000001; in_valid = 1'b1;
        tick();
        check("sim1_outA", outA, 32'h00000001);
        in1 = 32'h00000002; out_ready = 1'b1;
        tick();
        check("sim2_outA", outA, 32'h00000002);
        check("sim2_valid", {31'd0, out_valid}, 32'd1);
        check("sim2_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("sim3_valid", {31'd0, out_valid}, 32'd0);

        // Reset while full, with a concurrent input word
        out_ready = 1'b0; in1 = 32'hD1D1D1D1; in_valid = 1'b1;
        tick();
        in1 = 32'hD2D2D2D2;
        tick();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; in1 = 32'hE3E3E3E3;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("frst_valid", {31'd0, out_valid}, 32'd0);
        check("frst_in_ready", {31'd0, in_ready}, 32'd1);
        check("frst_outA", outA, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("frst_after%0d_valid", k), {31'd0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
